// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared types and parameter legality helpers for the multi-channel button
// debouncer.
//   deb_state_t        : per-channel debounce FSM state encoding
//   *_ok() functions   : parameter minimum checks used at elaboration
//   cnt_width()        : width of the stable-sample counter
//   hold_width()       : width of the long-press hold counter
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_WAIT_HIGH = 2'd1,
        S_HIGH      = 2'd2,
        S_WAIT_LOW  = 2'd3
    } deb_state_t;

    function automatic bit num_ch_ok(input int num_ch);
        return num_ch >= 1;
    endfunction

    function automatic bit sync_stages_ok(input int sync_stages);
        return sync_stages >= 2;
    endfunction

    function automatic bit stable_cycles_ok(input int stable_cycles);
        return stable_cycles >= 2;
    endfunction

    function automatic bit long_cycles_ok(input int long_cycles);
        return long_cycles >= 1;
    endfunction

    // Counter only needs to reach STABLE_CYCLES-1.
    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles);
    endfunction

    // Hold counter must be able to hold LONG_CYCLES itself (saturation value).
    function automatic int hold_width(input int long_cycles);
        return $clog2(long_cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One button channel: synchroniser chain, stable-count debounce FSM and
// long-press hold counter. All outputs are registered.
// Ports:
//   clk            in   clock, all logic on posedge
//   reset          in   asynchronous active-low reset
//   btn            in   raw button input, asynchronous to clk
//   level          out  debounced level
//   press_pulse    out  1-cycle pulse coincident with level rising
//   release_pulse  out  1-cycle pulse coincident with level falling
//   long_press     out  set after LONG_CYCLES cycles in S_HIGH, cleared on release
//   state          out  current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int LONG_CYCLES   = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    output logic       level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press,
    output deb_state_t state
);

    localparam int CNT_W  = cnt_width(STABLE_CYCLES);
    localparam int HOLD_W = hold_width(LONG_CYCLES);

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_SET = HOLD_W'(LONG_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchroniser: btn enters at bit 0, synced value taken from the top.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // FSM state and registered outputs
    // ------------------------------------------------------------------
    deb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_LOW;
            cnt_q     <= '0;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = long_q;

        case (state_q)
            S_LOW: begin
                if (s) begin
                    state_d = S_WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end

            S_WAIT_HIGH: begin
                if (!s) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_HIGH: begin
                // Hold counter advances every cycle spent here, including the
                // cycle that leaves for S_WAIT_LOW; it saturates at LONG_CYCLES
                // and long_press is set on the step that reaches it.
                if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HOLD_W'(1);
                    if (hold_q == HOLD_SET) begin
                        long_d = 1'b1;
                    end
                end
                if (!s) begin
                    state_d = S_WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end
            end

            S_WAIT_LOW: begin
                // Hold counter is frozen here so a rejected bounce resumes the
                // long-press timing where it left off.
                if (s) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_LOW;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    long_d    = 1'b0;
                    hold_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;
    assign state         = state_q;

endmodule

// File: rtl/btn_debounce_multi.sv
// -----------------------------------------------------------------------------
// btn_debounce_multi
// Multi-channel button debouncer: NUM_CH independent debounce_channel
// instances between raw board pins and the user-input logic.
// Ports:
//   clk            in   NUM_CH-independent single clock, posedge
//   reset          in   asynchronous active-low reset
//   btn_in         in   [NUM_CH-1:0] raw button inputs (asynchronous)
//   level_out      out  [NUM_CH-1:0] debounced levels
//   press_pulse    out  [NUM_CH-1:0] 1-cycle pulse on level_out rise
//   release_pulse  out  [NUM_CH-1:0] 1-cycle pulse on level_out fall
//   long_press     out  [NUM_CH-1:0] long-press flag, held until level_out falls
//   ch_state       out  [2*NUM_CH-1:0] per-channel FSM state, channel i in
//                       bits [2*i+1:2*i] (debug visibility)
// -----------------------------------------------------------------------------
module btn_debounce_multi
    import debounce_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int LONG_CYCLES   = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     btn_in,
    output logic [NUM_CH-1:0]     level_out,
    output logic [NUM_CH-1:0]     press_pulse,
    output logic [NUM_CH-1:0]     release_pulse,
    output logic [NUM_CH-1:0]     long_press,
    output logic [2*NUM_CH-1:0]   ch_state
);

    // Elaboration-time parameter checks.
    if (!num_ch_ok(NUM_CH)) begin : g_bad_num_ch
        $error("btn_debounce_multi: NUM_CH must be >= 1");
    end
    if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync
        $error("btn_debounce_multi: SYNC_STAGES must be >= 2");
    end
    if (!stable_cycles_ok(STABLE_CYCLES)) begin : g_bad_stable
        $error("btn_debounce_multi: STABLE_CYCLES must be >= 2");
    end
    if (!long_cycles_ok(LONG_CYCLES)) begin : g_bad_long
        $error("btn_debounce_multi: LONG_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        deb_state_t st;

        debounce_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES)
        ) u_channel (
            .clk           (clk),
            .reset         (reset),
            .btn           (btn_in[i]),
            .level         (level_out[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_press    (long_press[i]),
            .state         (st)
        );

        assign ch_state[2*i +: 2] = st;
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce_multi
// Directed testbench for btn_debounce_multi with NUM_CH=2, SYNC_STAGES=2,
// STABLE_CYCLES=4, LONG_CYCLES=10. Inputs are driven and outputs sampled
// 1 time unit after each rising edge. Accept latency is 5 clocks, so after
// changing btn_in the 6th following edge is the one that updates level_out.
// -----------------------------------------------------------------------------
module tb_btn_debounce_multi;

    localparam int NUM_CH = 2;

    logic              clk;
    logic              reset;
    logic [NUM_CH-1:0] btn_in;
    logic [NUM_CH-1:0] level_out;
    logic [NUM_CH-1:0] press_pulse;
    logic [NUM_CH-1:0] release_pulse;
    logic [NUM_CH-1:0] long_press;
    logic [2*NUM_CH-1:0] ch_state;

    int checks = 0;
    int errors = 0;

    btn_debounce_multi #(
        .NUM_CH        (NUM_CH),
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4),
        .LONG_CYCLES   (10)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_in        (btn_in),
        .level_out     (level_out),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .ch_state      (ch_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset  = 1'b0;
        btn_in = 2'b11;
        repeat (3) tick();
        checks++;
        if (level_out !== 2'b00) begin
            errors++; $display("FAIL reset_level: got %b expected 00", level_out);
        end
        checks++;
        if ({press_pulse, release_pulse, long_press} !== 6'b0) begin
            errors++; $display("FAIL reset_pulses: got %b expected 000000",
                               {press_pulse, release_pulse, long_press});
        end
        checks++;
        if (ch_state !== 4'b0000) begin
            errors++; $display("FAIL reset_state: got %b expected 0000", ch_state);
        end
        // Button held across reset release is a new press.
        reset = 1'b1;
        repeat (5) tick();
        checks++;
        if (level_out !== 2'b00) begin
            errors++; $display("FAIL held_press_early: got %b expected 00", level_out);
        end
        tick();
        checks++;
        if (level_out !== 2'b11 || press_pulse !== 2'b11) begin
            errors++; $display("FAIL held_press_rise: got level %b press %b expected 11 11",
                               level_out, press_pulse);
        end
        checks++;
        if (ch_state !== 4'b1010) begin
            errors++; $display("FAIL held_press_state: got %b expected 1010", ch_state);
        end
        tick();
        checks++;
        if (press_pulse !== 2'b00 || level_out !== 2'b11) begin
            errors++; $display("FAIL held_press_one_cycle: got level %b press %b expected 11 00",
                               level_out, press_pulse);
        end
        btn_in = 2'b00;
        repeat (6) tick();
        checks++;
        if (level_out !== 2'b00 || release_pulse !== 2'b11) begin
            errors++; $display("FAIL reset_both_release: got level %b release %b expected 00 11",
                               level_out, release_pulse);
        end
        tick();
        checks++;
        if (release_pulse !== 2'b00) begin
            errors++; $display("FAIL reset_release_one_cycle: got %b expected 00", release_pulse);
        end
    endtask

    task automatic test_glitch();
        // Three synced samples high is one short of acceptance.
        btn_in = 2'b01;
        repeat (3) tick();
        btn_in = 2'b00;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (level_out !== 2'b00 || press_pulse !== 2'b00 || release_pulse !== 2'b00) begin
                errors++; $display("FAIL glitch_cycle%0d: got level %b press %b release %b expected 00 00 00",
                                   i, level_out, press_pulse, release_pulse);
            end
        end
    endtask

    task automatic test_press_release_ch1();
        btn_in = 2'b10;
        repeat (5) tick();
        checks++;
        if (level_out !== 2'b00) begin
            errors++; $display("FAIL ch1_rise_early: got %b expected 00", level_out);
        end
        tick();
        checks++;
        if (level_out !== 2'b10 || press_pulse !== 2'b10) begin
            errors++; $display("FAIL ch1_rise: got level %b press %b expected 10 10",
                               level_out, press_pulse);
        end
        tick();
        checks++;
        if (press_pulse !== 2'b00) begin
            errors++; $display("FAIL ch1_press_one_cycle: got %b expected 00", press_pulse);
        end
        repeat (4) tick();
        btn_in = 2'b00;
        repeat (5) tick();
        checks++;
        if (level_out !== 2'b10 || release_pulse !== 2'b00) begin
            errors++; $display("FAIL ch1_fall_early: got level %b release %b expected 10 00",
                               level_out, release_pulse);
        end
        tick();
        checks++;
        if (level_out !== 2'b00 || release_pulse !== 2'b10) begin
            errors++; $display("FAIL ch1_fall: got level %b release %b expected 00 10",
                               level_out, release_pulse);
        end
        tick();
        checks++;
        if (release_pulse !== 2'b00) begin
            errors++; $display("FAIL ch1_release_one_cycle: got %b expected 00", release_pulse);
        end
    endtask

    task automatic test_bounce_release();
        btn_in = 2'b01;
        repeat (6) tick();
        checks++;
        if (level_out !== 2'b01 || press_pulse !== 2'b01) begin
            errors++; $display("FAIL bounce_press: got level %b press %b expected 01 01",
                               level_out, press_pulse);
        end
        btn_in = 2'b00;
        repeat (2) tick();
        btn_in = 2'b01;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (level_out !== 2'b01 || release_pulse !== 2'b00) begin
                errors++; $display("FAIL bounce_cycle%0d: got level %b release %b expected 01 00",
                                   i, level_out, release_pulse);
            end
        end
        btn_in = 2'b00;
        repeat (6) tick();
        checks++;
        if (level_out !== 2'b00 || release_pulse !== 2'b01 || long_press !== 2'b00) begin
            errors++; $display("FAIL bounce_final_release: got level %b release %b long %b expected 00 01 00",
                               level_out, release_pulse, long_press);
        end
        repeat (2) tick();
    endtask

    task automatic test_long_press();
        btn_in = 2'b01;
        repeat (6) tick();
        checks++;
        if (level_out !== 2'b01 || long_press !== 2'b00) begin
            errors++; $display("FAIL long_rise: got level %b long %b expected 01 00",
                               level_out, long_press);
        end
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++;
            if (long_press !== 2'b00) begin
                errors++; $display("FAIL long_early_%0d: got %b expected 00", i, long_press);
            end
        end
        tick();
        checks++;
        if (long_press !== 2'b01) begin
            errors++; $display("FAIL long_set: got %b expected 01", long_press);
        end
        // Well past the hold counter's natural wrap point: must stay set.
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (long_press !== 2'b01 || level_out !== 2'b01) begin
                errors++; $display("FAIL long_hold_%0d: got long %b level %b expected 01 01",
                                   i, long_press, level_out);
            end
        end
        btn_in = 2'b00;
        repeat (5) tick();
        checks++;
        if (long_press !== 2'b01 || level_out !== 2'b01) begin
            errors++; $display("FAIL long_until_fall: got long %b level %b expected 01 01",
                               long_press, level_out);
        end
        tick();
        checks++;
        if (level_out !== 2'b00 || long_press !== 2'b00 || release_pulse !== 2'b01) begin
            errors++; $display("FAIL long_clear: got level %b long %b release %b expected 00 00 01",
                               level_out, long_press, release_pulse);
        end
        repeat (2) tick();
    endtask

    task automatic test_async_reset();
        btn_in = 2'b01;
        repeat (6) tick();
        checks++;
        if (level_out !== 2'b01) begin
            errors++; $display("FAIL async_pre: got %b expected 01", level_out);
        end
        // Assert reset between edges: outputs must drop with no clock.
        reset = 1'b0;
        #1;
        checks++;
        if ({level_out, press_pulse, release_pulse, long_press} !== 8'b0) begin
            errors++; $display("FAIL async_drop: got %b expected 00000000",
                               {level_out, press_pulse, release_pulse, long_press});
        end
        btn_in = 2'b00;
        repeat (3) tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (level_out !== 2'b00 || release_pulse !== 2'b00 || press_pulse !== 2'b00) begin
                errors++; $display("FAIL async_after_%0d: got level %b press %b release %b expected 00 00 00",
                                   i, level_out, press_pulse, release_pulse);
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        reset  = 1'b0;
        btn_in = '0;
        test_reset();
        test_glitch();
        test_press_release_ch1();
        test_bounce_release();
        test_long_press();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
